// File: rtl/lfsr_checker.sv
// lfsr_checker: PRBS receiver that self-synchronises to an LFSR stream, locks after
// a run of correct predictions, then counts bit errors against a free-running reference.
module lfsr_checker #(
  parameter int NBITS = 8,
  parameter logic [NBITS-1:0] TAPS = 8'h1D,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bit_in,
  input  logic        clr_count,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);
  localparam int CMAX = NBITS > LOCK_COUNT ? NBITS : LOCK_COUNT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state_q, state_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic locked_q, locked_d, err_q, err_d;
  logic [15:0] err_count_q, err_count_d, err_base;
  logic pred, new_bit, miss_hit;
  always_comb begin
    pred = ^(r_q & TAPS);
    new_bit = state_q == LOCKED ? pred : bit_in;
    r_d = en ? {new_bit, r_q[NBITS-1:1]} : r_q;
    miss_hit = en && state_q == LOCKED && bit_in != pred;
    cnt_inc = cnt_q + 1'b1;
    miss_inc = miss_q + 1'b1;
    state_d = state_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    if (en && state_q == SEARCH) begin
      state_d = cnt_inc == CW'(NBITS) ? VERIFY : SEARCH;
      cnt_d = cnt_inc == CW'(NBITS) ? '0 : cnt_inc;
    end else if (en && state_q == VERIFY) begin
      // an all-zero window predicts zeros forever, so it must never build up a lock
      cnt_d = (bit_in != pred || r_d == '0) ? '0 : cnt_inc;
      state_d = cnt_d == CW'(LOCK_COUNT) ? LOCKED : VERIFY;
      miss_d = '0;
    end else if (en && state_q == LOCKED) begin
      miss_d = miss_hit ? miss_inc : '0;
      state_d = (miss_hit && miss_inc == MW'(LOSS_COUNT)) ? SEARCH : LOCKED;
      cnt_d = state_d == SEARCH ? '0 : cnt_q;
    end
    err_base = clr_count ? 16'd0 : err_count_q;
    err_count_d = (miss_hit && err_base != 16'hFFFF) ? err_base + 16'd1 : err_base;
    locked_d = state_d == LOCKED;
    err_d = miss_hit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      r_q <= '0;
      cnt_q <= '0;
      miss_q <= '0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      locked_q <= locked_d;
      err_q <= err_d;
      err_count_q <= err_count_d;
    end
  end
  assign locked = locked_q;
  assign err = err_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed PRBS scenarios checked every cycle against a
// window-of-history model, plus literal lock-point and error-count expectations.
module tb_lfsr_checker;
  localparam logic [7:0] TAPS = 8'h1D;
  logic clk = 0, rst = 0, en = 0, bit_in = 0, clr_count = 0;
  logic locked, err;
  logic [15:0] err_count;
  int nvec = 0, nmis = 0, acc = 0, nerr = 0, at;
  logic on = 0;
  logic [7:0] g;
  bit hist[$];
  int m_phase, m_fill, m_run, m_miss, m_cnt;
  logic m_err;

  lfsr_checker dut (.clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_count(clr_count),
                    .locked(locked), .err(err), .err_count(err_count));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // model phases: 0 = searching (filling), 1 = verifying, 2 = locked
  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    m_phase = 0; m_fill = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_step(input logic e, input logic b, input logic c);
    bit p, nb, mism, zero;
    p = 0;
    mism = 0;
    for (int i = 0; i < 8; i++) if (TAPS[i]) p ^= hist[i];
    if (e) begin
      mism = (m_phase == 2) && (b != p);
      nb = (m_phase == 2) ? p : b;
      hist.push_back(nb);
      void'(hist.pop_front());
      if (m_phase == 0) begin
        m_fill++;
        if (m_fill == 8) begin m_phase = 1; m_run = 0; end
      end else if (m_phase == 1) begin
        zero = 1;
        foreach (hist[i]) if (hist[i]) zero = 0;
        m_run = (b == p && !zero) ? m_run + 1 : 0;
        if (m_run == 16) begin m_phase = 2; m_miss = 0; end
      end else if (mism) begin
        m_miss++;
        if (m_miss == 4) begin m_phase = 0; m_fill = 0; end
      end else m_miss = 0;
    end
    if (c) m_cnt = 0;
    if (mism && m_cnt < 65535) m_cnt++;
    m_err = mism;
  endtask

  always @(negedge clk) if (!rst && on) begin
    chk("locked", locked, m_phase == 2);
    chk("err", err, m_err);
    chk("err_count", err_count, m_cnt);
  end

  task automatic next_bit(output logic b);
    b = ^(g & TAPS);
    g = {b, g[7:1]};
  endtask

  task automatic step(input logic e, input logic b, input logic c);
    en = e; bit_in = b; clr_count = c;
    @(posedge clk);
    model_step(e, b, c);
    #1;
    if (e) acc++;
    if (err) nerr++;
  endtask

  task automatic pulse_reset();
    rst = 1; en = 0; clr_count = 0;
    model_reset();
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    @(posedge clk);
    #1;
    rst = 0; acc = 0; g = 8'h01;
  endtask

  task automatic lock_up(input int budget, output int at_o);
    logic b;
    at_o = -1;
    for (int i = 1; i <= budget && at_o < 0; i++) begin
      next_bit(b);
      step(1, b, 0);
      if (locked) at_o = i;
    end
  endtask

  initial begin
    logic b, anyl;
    #2;
    pulse_reset();
    on = 1;
    lock_up(100, at);
    chk("clean_lock_at", at, 24);
    nerr = 0;
    for (int i = 0; i < 1000; i++) begin next_bit(b); step(1, b, 0); end
    chk("clean_errs", nerr, 0);
    chk("clean_count", err_count, 0);
    next_bit(b); step(1, b ^ 1'b1, 0);
    chk("single_err_pulse", err, 1);
    for (int i = 0; i < 50; i++) begin next_bit(b); step(1, b, 0); end
    chk("single_errs", nerr, 1);
    chk("single_count", err_count, 1);
    chk("single_locked", locked, 1);
    next_bit(b); step(1, b, 1);
    chk("clr_count", err_count, 0);
    for (int i = 0; i < 3; i++) begin next_bit(b); step(1, b ^ 1'b1, 0); end
    chk("loss_hold3", locked, 1);
    next_bit(b); step(1, b ^ 1'b1, 0);
    chk("loss_locked", locked, 0);
    chk("loss_count", err_count, 4);
    lock_up(100, at);
    chk("relock_at", at, 24);
    next_bit(b); step(1, b ^ 1'b1, 1);
    chk("clr_err_count", err_count, 1);
    chk("clr_err_pulse", err, 1);
    for (int k = 0; k < 4; k++) begin
      next_bit(b); step(1, b ^ 1'b1, 0);
      for (int i = 0; i < 3; i++) begin next_bit(b); step(1, b, 0); end
    end
    chk("pre_rst_count", err_count, 5);
    chk("pre_rst_locked", locked, 1);
    on = 0;
    pulse_reset();
    on = 1;
    anyl = 0;
    for (int i = 0; i < 200; i++) begin step(1, 0, 0); anyl |= locked; end
    chk("zero_never_lock", anyl, 0);
    on = 0;
    pulse_reset();
    on = 1;
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      repeat ($urandom_range(0, 2)) step(0, 1'($urandom), 0);
      next_bit(b);
      step(1, b, 0);
      if (locked) at = acc;
    end
    chk("gap_lock_at", at, 24);
    on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL provide parameter NBITS, default 8, the LFSR length.
REQ-002 The block SHALL provide parameter TAPS, default 8'h1D, the feedback mask; bit i set means stream bit t-NBITS+i feeds the XOR.
REQ-003 The block SHALL provide parameter LOCK_COUNT, default 16, the consecutive matches required to lock.
REQ-004 The block SHALL provide parameter LOSS_COUNT, default 4, the consecutive mismatches that drop lock.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en, input, width 1: bit_in is accepted on any rising edge with en=1.
REQ-008 The block SHALL have port bit_in, input, width 1: the received serial PRBS bit.
REQ-009 The block SHALL have port clr_count, input, width 1: synchronous clear of err_count.
REQ-010 The block SHALL have port locked, output, width 1: high in state LOCKED.
REQ-011 The block SHALL have port err, output, width 1: one-cycle pulse per mismatch while LOCKED.
REQ-012 The block SHALL have port err_count, output, width 16: saturating count of LOCKED mismatches.

Function
REQ-013 The block SHALL hold reference register r[NBITS-1:0], shifting right on accept: r <= {new_bit, r[NBITS-1:1]}.
REQ-014 The predicted bit SHALL be the XOR-reduction of (r AND TAPS), computed from r before the shift.
REQ-015 The block SHALL implement states SEARCH, VERIFY and LOCKED, with a fill/match counter and a miss counter.
REQ-016 In SEARCH, new_bit SHALL be bit_in; after NBITS accepted bits the block SHALL enter VERIFY with the counter cleared.
REQ-017 In VERIFY, new_bit SHALL be bit_in; a match SHALL increment the counter and a mismatch SHALL clear it.
REQ-018 In VERIFY, a match whose updated r is all-zero SHALL clear the counter, so that lock never occurs on the all-zero stream.
REQ-019 When the counter reaches LOCK_COUNT, the block SHALL enter LOCKED and clear the miss counter.
REQ-020 In LOCKED, new_bit SHALL be the predicted bit (free-running), so a single channel error is counted exactly once.
REQ-021 In LOCKED, a mismatch SHALL assert err for exactly one cycle, increment err_count saturating at 16'hFFFF, and increment the miss counter.
REQ-022 In LOCKED, a match SHALL clear the miss counter.
REQ-023 When the miss counter reaches LOSS_COUNT, the block SHALL return to SEARCH with the counter cleared; the mismatch that triggers the transition is still counted.
REQ-024 Outputs SHALL be registered: locked, err and err_count reflect accepted bit k on the edge that accepts bit k.
REQ-025 With en=0, all state, r and counters SHALL hold, and err SHALL be 0.
REQ-026 clr_count=1 SHALL zero err_count; if a mismatch is accepted on the same edge, err_count SHALL become 1 and err SHALL still pulse.
REQ-027 Counters SHALL be sized to hold max(NBITS, LOCK_COUNT) and LOSS_COUNT without wrap-around.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state=SEARCH, r=0, all counters=0, locked=0, err=0 and err_count=0.
REQ-029 Reset asserted mid-operation SHALL discard lock immediately, with no err pulse.
REQ-030 After rst deasserts, the first accepted bit SHALL be treated as fill bit 0 of SEARCH.

Verification
REQ-031 The bench SHALL cover clean lock: a Fibonacci generator with seed 8'h01 and TAPS 8'h1D, en=1 continuously -> locked rises on the edge of accepted bit 24; err=0 and err_count=0 for the following 1000 bits.
REQ-032 The bench SHALL cover a single error: after lock, invert one bit -> exactly one err pulse, err_count=1, locked stays 1, and no further errors occur.
REQ-033 The bench SHALL cover loss of lock: after lock, invert 4 consecutive bits -> err_count=4 and locked falls on the 4th; then with a clean stream, relock occurs 24 accepted bits later.
REQ-034 The bench SHALL cover the all-zero stream: 200 zero bits -> locked remains 0 throughout.
REQ-035 The bench SHALL cover en gaps and clear: with random en=0 gaps, lock still occurs at accepted bit 24; clr_count coincident with an error gives err_count=1.
REQ-036 The bench SHALL cover reset mid-operation: asserting rst while LOCKED with err_count=5 -> locked=0 and err_count=0 before the next clock edge.
